sprite_65: RTL and testbench

// - Renders one 64x64-pixel on-screen sprite into the VGA pixel stream.
// - Compares the scan position from the VGA timing generator with the sprite origin.
// - Inside the sprite: fetches a 3-bit colour index from a 32x32 ROM, drawn at 2x scale,
//   and maps it through an 8-entry palette to 24-bit RGB.
// - Outside the sprite, and for index 0 (transparent): outputs black. The VGA mux consumes RGB.

---
 rtl/sprite_pkg.sv | 15 +
 rtl/sprite_rom.sv | 30 +++
 rtl/sprite_65.sv | 52 +++++
 tb/tb_sprite_65.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types, palette and default geometry for the sprite renderer.
package sprite_pkg;
  typedef logic [23:0] rgb_t;
  typedef logic [2:0]  cidx_t;
  localparam int SPR_SIZE_DEF = 64;
  localparam int ROM_DIM_DEF  = 32;
  localparam rgb_t PALETTE [8] = '{
    24'h000000, 24'hFF0000, 24'h00FF00, 24'h0000FF,
    24'hFFFF00, 24'h00FFFF, 24'hFF00FF, 24'hFFFFFF
  };
  // Built-in sprite image: texel a holds colour index a mod 8.
  function automatic cidx_t image_word(int a);
    return cidx_t'(a % 8);
  endfunction
endpackage

// File: rtl/sprite_rom.sv
// sprite_rom: DEPTH x 3-bit single-port ROM with a registered read port.
module sprite_rom
  import sprite_pkg::*;
#(
  parameter int DEPTH = ROM_DIM_DEF * ROM_DIM_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr_i,
  output cidx_t         data_o
);
  function automatic logic [DEPTH*3-1:0] build_image();
    logic [DEPTH*3-1:0] img;
    img = '0;
    for (int a = 0; a < DEPTH; a++) img[a*3 +: 3] = image_word(a);
    return img;
  endfunction

  localparam logic [DEPTH*3-1:0] IMAGE = build_image();

  cidx_t data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= IMAGE[int'(addr_i)*3 +: 3];
  end

  assign data_o = data_q;
endmodule

// File: rtl/sprite_65.sv
// sprite_65: renders a 2x-scaled 32x32 palette sprite into the VGA pixel stream.
// Two-stage pipeline: ROM fetch + hit flag, then palette lookup into the RGB register.
module sprite_65
  import sprite_pkg::*;
#(
  parameter int SPR_SIZE = SPR_SIZE_DEF,
  parameter int ROM_DIM  = ROM_DIM_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  posx,
  input  logic [9:0]  posy,
  input  logic [9:0]  counterX,
  input  logic [9:0]  counterY,
  output logic [23:0] RGB
);
  localparam int SB = $clog2(SPR_SIZE / ROM_DIM);
  localparam int RB = $clog2(ROM_DIM);

  logic [10:0]     dx, dy;
  logic            hit, hit_q;
  logic [2*RB-1:0] addr;
  cidx_t           color;
  rgb_t            rgb_q;
  logic            unused_lsb;

  // Offsets carry a borrow bit so a sprite near 1023 clips instead of wrapping.
  assign dx         = {1'b0, counterX} - {1'b0, posx};
  assign dy         = {1'b0, counterY} - {1'b0, posy};
  assign hit        = !dx[10] && !dy[10] && dx < 11'(SPR_SIZE) && dy < 11'(SPR_SIZE);
  assign addr       = {dy[SB +: RB], dx[SB +: RB]};
  assign unused_lsb = ^{dx[SB-1:0], dy[SB-1:0]};

  sprite_rom #(.DEPTH(ROM_DIM * ROM_DIM)) u_rom (
    .clk    (clk),
    .rst_n  (rst_n),
    .addr_i (addr),
    .data_o (color)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q <= 1'b0;
      rgb_q <= '0;
    end else begin
      hit_q <= hit;
      rgb_q <= hit_q ? PALETTE[color] : '0;
    end
  end

  assign RGB = rgb_q;
endmodule

// File: tb/tb_sprite_65.sv
// tb_sprite_65: randomized scoreboard bench for sprite_65 against a geometric reference model.
module tb_sprite_65;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [9:0]  posx = '0, posy = '0, counterX = '0, counterY = '0;
  logic [23:0] RGB;

  always #5 clk = ~clk;

  sprite_65 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .posx     (posx),
    .posy     (posy),
    .counterX (counterX),
    .counterY (counterY),
    .RGB      (RGB)
  );

  typedef struct {
    logic [23:0] exp;
    int          due;
    int          id;
  } item_t;

  item_t q[$];
  int cyc = 0, n_cmp = 0, n_bad = 0, n_id = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] colour(int idx);
    case (idx)
      1: return 24'hFF0000;
      2: return 24'h00FF00;
      3: return 24'h0000FF;
      4: return 24'hFFFF00;
      5: return 24'h00FFFF;
      6: return 24'hFF00FF;
      7: return 24'hFFFFFF;
      default: return 24'h000000;
    endcase
  endfunction

  // Sprite covers [pos, pos+63] in each axis; each ROM texel is 2x2 pixels; rom[a] = a mod 8.
  function automatic logic [23:0] model(logic [9:0] cx, logic [9:0] cy, logic [9:0] px, logic [9:0] py);
    int dx, dy;
    dx = int'(cx) - int'(px);
    dy = int'(cy) - int'(py);
    if (dx < 0 || dx >= 64 || dy < 0 || dy >= 64) return 24'h000000;
    return colour(((dy / 2) * 32 + dx / 2) % 8);
  endfunction

  task automatic drive(input logic [9:0] cx, input logic [9:0] cy, input logic [9:0] px, input logic [9:0] py);
    item_t it;
    @(negedge clk);
    counterX = cx;
    counterY = cy;
    posx     = px;
    posy     = py;
    if (rst_n) begin
      it = '{model(cx, cy, px, py), cyc + 2, n_id};
      q.push_back(it);
      n_id++;
    end
  endtask

  task automatic check_now(input string name, input logic [23:0] exp);
    n_cmp++;
    if (RGB !== exp) begin
      n_bad++;
      $display("FAIL %s: RGB=%h expected=%h", name, RGB, exp);
    end
  endtask

  always @(posedge clk) begin
    item_t it;
    #1;
    while (q.size() > 0 && q[0].due <= cyc) begin
      it = q.pop_front();
      n_cmp++;
      if (it.due != cyc) begin
        n_bad++;
        $display("FAIL pixel#%0d: check missed at cycle %0d (due %0d)", it.id, cyc, it.due);
      end else if (RGB !== it.exp) begin
        n_bad++;
        $display("FAIL pixel#%0d: RGB=%h expected=%h", it.id, RGB, it.exp);
      end
    end
  end

  initial begin
    item_t it;
    logic [9:0] px, py, cx, cy;
    #2 rst_n = 1'b0;
    #1 check_now("reset_value", 24'h000000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drive(10'd90,  10'd40,  10'd100, 10'd50);
    drive(10'd100, 10'd40,  10'd100, 10'd50);
    drive(10'd100, 10'd50,  10'd100, 10'd50);
    drive(10'd101, 10'd51,  10'd100, 10'd50);
    drive(10'd102, 10'd50,  10'd100, 10'd50);
    drive(10'd105, 10'd55,  10'd100, 10'd50);
    drive(10'd163, 10'd113, 10'd100, 10'd50);
    drive(10'd164, 10'd50,  10'd100, 10'd50);
    drive(10'd99,  10'd50,  10'd100, 10'd50);
    drive(10'd100, 10'd114, 10'd100, 10'd50);
    drive(10'd5,   10'd50,  10'd1000, 10'd50);
    drive(10'd1023, 10'd50, 10'd1000, 10'd50);
    drive(10'd163, 10'd113, 10'd100, 10'd50);
    drive(10'd163, 10'd113, 10'd100, 10'd50);
    drive(10'd163, 10'd113, 10'd100, 10'd50);
    // Pipeline now holds a white pixel; reset must clear it at once.
    #2 rst_n = 1'b0;
    q.delete();
    #1 check_now("reset_midstream", 24'h000000);
    repeat (2) @(negedge clk);
    check_now("reset_held", 24'h000000);
    @(negedge clk);
    rst_n = 1'b1;
    it = '{24'hFFFFFF, cyc + 2, n_id};
    q.push_back(it);
    n_id++;
    for (int i = 0; i < 3000; i++) begin
      px = 10'($urandom_range(0, 1023));
      py = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 7) == 0) begin
        cx = 10'($urandom_range(0, 1023));
        cy = 10'($urandom_range(0, 1023));
      end else begin
        cx = 10'(int'(px) + int'($urandom_range(0, 80)) - 8);
        cy = 10'(int'(py) + int'($urandom_range(0, 80)) - 8);
      end
      drive(cx, cy, px, py);
    end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d pending checks, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
